// File: rtl/ipml_prefetch_fifo_downsizer_v1_0.sv
// ---------------------------------------------------------------------------
// ipml_prefetch_fifo_downsizer_v1_0
//   Width-reducing stage placed directly after the prefetch FIFO read port.
//   It takes one IN_W-bit word per valid/ready transfer and replays it as
//   RATIO consecutive OUT_W-bit slices. With back-to-back words it sustains
//   one slice per clock, and the FIFO is polled only once per word.
//
// Ports
//   clk       in   single clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   [IN_W]   word from FIFO rd_data
//   in_vld    in   word valid (FIFO rd_vld)
//   in_rdy    out  word accepted when in_vld & in_rdy (drives FIFO rd_en)
//   out_data  out  [OUT_W]  current slice
//   out_vld   out  slice valid
//   out_rdy   in   downstream accepts slice when out_vld & out_rdy
//   out_last  out  current slice is the final slice of its word
//   flush     in   synchronous discard of the held word
//   busy      out  a word is held (same as out_vld)
// ---------------------------------------------------------------------------
module ipml_prefetch_fifo_downsizer_v1_0 #(
    parameter int IN_W      = 32,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic [IN_W/RATIO-1:0]   out_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    out_last,
    input  logic                    flush,
    output logic                    busy
);

    localparam int OUT_W = IN_W / RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [IN_W-1:0]  hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             last;
    logic             load;
    logic             accept;
    logic [IDX_W-1:0] sel;

    assign last     = (idx_q == IDX_LAST);

    // A new word is taken when the holder is empty or its last slice is
    // leaving this cycle; that overlap is what removes the bubble between
    // words. Never depends on in_vld, so there is no loop through the FIFO.
    assign in_rdy   = ~flush & (~hold_vld_q | (out_rdy & last));
    assign load     = in_vld & in_rdy;
    assign accept   = hold_vld_q & out_rdy;

    assign out_vld  = hold_vld_q;
    assign busy     = hold_vld_q;
    assign out_last = hold_vld_q & last;

    // Slice order: idx counts emitted slices; map it to a physical slice.
    assign sel = (LSB_FIRST != 0) ? idx_q : (IDX_LAST - idx_q);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel == IDX_W'(i)) out_data = hold_q[i*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        idx_d      = idx_q;
        if (flush) begin
            // Drop the rest of the word; in_rdy is low so nothing loads.
            hold_vld_d = 1'b0;
            idx_d      = '0;
        end else if (load) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
            idx_d      = '0;
        end else if (accept) begin
            if (last) begin
                hold_vld_d = 1'b0;
                idx_d      = '0;
            end else begin
                idx_d      = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            idx_q      <= idx_d;
        end
    end

endmodule

// File: tb/tb_ipml_prefetch_fifo_downsizer_v1_0.sv
module tb_ipml_prefetch_fifo_downsizer_v1_0;

    // Three instances share stimulus: [0] RATIO=4 LSB first, [1] RATIO=4 MS first,
    // [2] RATIO=1 (8-bit pipe). Each has its own queue-based reference model.
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic        flush = 1'b0;

    logic [2:0]      irdy, ovld, olast, obusy;
    logic [2:0][7:0] odat;

    int ncmp = 0;
    int nbad = 0;

    int rat [3] = '{4, 4, 1};
    int lsb [3] = '{1, 0, 1};

    logic [7:0] mq  [3][$];   // expected remaining slices per instance
    logic [7:0] cap [3][$];   // slices actually accepted downstream

    always #5 clk = ~clk;

    ipml_prefetch_fifo_downsizer_v1_0 #(.IN_W(32), .RATIO(4), .LSB_FIRST(1)) u_l (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(irdy[0]),
        .out_data(odat[0]), .out_vld(ovld[0]), .out_rdy(out_rdy), .out_last(olast[0]),
        .flush(flush), .busy(obusy[0]));

    ipml_prefetch_fifo_downsizer_v1_0 #(.IN_W(32), .RATIO(4), .LSB_FIRST(0)) u_m (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(irdy[1]),
        .out_data(odat[1]), .out_vld(ovld[1]), .out_rdy(out_rdy), .out_last(olast[1]),
        .flush(flush), .busy(obusy[1]));

    ipml_prefetch_fifo_downsizer_v1_0 #(.IN_W(8), .RATIO(1), .LSB_FIRST(1)) u_1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_vld(in_vld), .in_rdy(irdy[2]),
        .out_data(odat[2]), .out_vld(ovld[2]), .out_rdy(out_rdy), .out_last(olast[2]),
        .flush(flush), .busy(obusy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes RATIO slices in emission order, pushed on a queue.
    function automatic logic [7:0] slice_of(input int m, input logic [31:0] w, input int k);
        int s;
        s = (lsb[m] != 0) ? k : rat[m] - 1 - k;
        return 8'(w >> (s * 8));
    endfunction

    // Called at the negedge with inputs stable: check outputs, then advance models.
    task automatic check_models();
        bit ev, er, acc;
        for (int m = 0; m < 3; m++) begin
            if (!rst_n) mq[m].delete();
            ev = (mq[m].size() != 0);
            er = !flush && (!ev || (out_rdy && mq[m].size() == 1));
            chk($sformatf("m%0d out_vld", m), 32'(ovld[m]), 32'(ev));
            chk($sformatf("m%0d in_rdy", m), 32'(irdy[m]), 32'(er));
            chk($sformatf("m%0d out_last", m), 32'(olast[m]), 32'(ev && mq[m].size() == 1));
            chk($sformatf("m%0d busy", m), 32'(obusy[m]), 32'(ev));
            if (ev) chk($sformatf("m%0d out_data", m), 32'(odat[m]), 32'(mq[m][0]));
            acc = ovld[m] && out_rdy;
            if (acc && rst_n) cap[m].push_back(odat[m]);
            if (rst_n) begin
                if (ev && out_rdy) void'(mq[m].pop_front());
                if (flush) mq[m].delete();
                else if (in_vld && er)
                    for (int k = 0; k < rat[m]; k++) mq[m].push_back(slice_of(m, in_data, k));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_models();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        for (int m = 0; m < 3; m++) cap[m].delete();
    endtask

    task automatic chk_cap(input string name, input int m, input logic [7:0] exp [$]);
        chk({name, " count"}, 32'(cap[m].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap[m].size(); i++)
            chk($sformatf("%s[%0d]", name, i), 32'(cap[m][i]), 32'(exp[i]));
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        ordy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic        e_last;
        logic        e_rdy;
    } vec_t;

    vec_t tv [15];

    initial begin
        logic [7:0] e [$];

        // Words 0xA1B2C3D4, then back-to-back 0x03020100 / 0x07060504, out_rdy=1.
        tv[0]  = '{1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hD4, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hB2, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
        tv[5]  = '{1'b1, 32'h03020100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[6]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1};
        tv[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h04, 1'b0, 1'b0};
        tv[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h05, 1'b0, 1'b0};
        tv[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h06, 1'b0, 1'b0};
        tv[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h07, 1'b1, 1'b1};
        tv[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_vld", 32'(ovld[0]), 32'd0);
        chk("rst in_rdy", 32'(irdy[0]), 32'd1);
        chk("rst out_last", 32'(olast[0]), 32'd0);
        chk("rst out_data", 32'(odat[0]), 32'd0);
        chk("rst busy", 32'(obusy[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table on the LSB-first instance
        for (int i = 0; i < 15; i++) begin
            in_vld = tv[i].vld; in_data = tv[i].data; out_rdy = tv[i].ordy; flush = 1'b0;
            @(negedge clk);
            chk($sformatf("tv%0d out_vld", i), 32'(ovld[0]), 32'(tv[i].e_vld));
            chk($sformatf("tv%0d in_rdy", i), 32'(irdy[0]), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d out_last", i), 32'(olast[0]), 32'(tv[i].e_last));
            if (tv[i].e_vld) chk($sformatf("tv%0d out_data", i), 32'(odat[0]), 32'(tv[i].e_data));
            check_models();
            @(posedge clk);
            #1;
        end
        repeat (3) step();

        // MS-first ordering
        clear_caps();
        in_vld = 1'b1; in_data = 32'h11223344; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (6) step();
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk_cap("msb order", 1, e);

        // Backpressure 1,0,0,1,...: slices held, order unchanged
        clear_caps();
        in_vld = 1'b1; in_data = 32'h44332211;
        for (int k = 0; k < 16; k++) begin
            out_rdy = (k % 3 == 0);
            step();
            in_vld = 1'b0;
        end
        out_rdy = 1'b1;
        repeat (3) step();
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk_cap("stall order", 0, e);

        // Flush after slice 1 of 0xDEADBEEF
        clear_caps();
        in_vld = 1'b1; in_data = 32'hDEADBEEF; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        step();                   // EF
        flush = 1'b1;
        step();                   // BE accepted, rest discarded
        flush = 1'b0; in_vld = 1'b1; in_data = 32'h44332211;
        @(negedge clk);
        chk("flush out_vld", 32'(ovld[0]), 32'd0);
        chk("flush in_rdy", 32'(irdy[0]), 32'd1);
        check_models();
        @(posedge clk);
        #1 in_vld = 1'b0;
        @(negedge clk);
        chk("post-flush slice0", 32'(odat[0]), 32'h11);
        check_models();
        @(posedge clk);
        #1;
        repeat (5) step();
        e = '{8'hEF, 8'hBE, 8'h11, 8'h22, 8'h33, 8'h44};
        chk_cap("flush seq", 0, e);

        // Reset mid-word
        clear_caps();
        in_vld = 1'b1; in_data = 32'h0A0B0C0D;
        step();
        in_vld = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("mid-rst m%0d out_vld", m), 32'(ovld[m]), 32'd0);
            chk($sformatf("mid-rst m%0d in_rdy", m), 32'(irdy[m]), 32'd1);
        end
        step();
        rst_n = 1'b1;
        clear_caps();
        in_vld = 1'b1; in_data = 32'h44332211;
        step();
        in_vld = 1'b0;
        repeat (5) step();
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk_cap("post-rst seq", 0, e);
        e = '{8'h11};
        chk_cap("post-rst r1", 2, e);

        // Randomized traffic against the models
        for (int c = 0; c < 3000; c++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            out_rdy = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 19) == 0);
            step();
        end
        in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
